// File: rtl/i2c_bert_controller.sv
// I2C initiator: one bus primitive (START/WRITE/READ/STOP) per command, open-drain SCL/SDA.
// Latency: 4*CLKDIV cycles per quarter-set (START/STOP 16+1, byte 9*16+1 at CLKDIV=4) plus stretch time.
// Backpressure: cmd_ready is low from acceptance until the rsp_valid cycle; the timer freezes while a released SCL reads low.
module i2c_bert_controller #(
    parameter int CLKDIV = 4,
    parameter int CNTW   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_rd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_ack,
    output logic       rsp_err,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);
    localparam logic [1:0]      OP_START = 2'd0;
    localparam logic [1:0]      OP_READ  = 2'd2;
    localparam logic [1:0]      OP_STOP  = 2'd3;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CLKDIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_RESP} state_t;

    state_t          state, state_nxt;
    logic [1:0]      q, q_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [3:0]      slot, slot_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic [7:0]      rsp_rdata_nxt;
    logic            rd_op, rd_op_nxt;
    logic            nack, nack_nxt;
    logic            ack_smp, ack_smp_nxt;
    logic            busy_nxt, scl_oe_nxt, sda_oe_nxt, rsp_ack_nxt, rsp_err_nxt;
    logic            active, stretch, q_end, last_slot;

    assign cmd_ready = (state == S_IDLE) || (state == S_RESP);
    assign rsp_valid = (state == S_RESP);
    assign active    = (state == S_START) || (state == S_BIT) || (state == S_STOP);
    // A released SCL that still reads low is a target holding the clock.
    assign stretch   = ~scl_oe & ~scl_i;
    assign q_end     = (cnt == CNT_LAST) & ~stretch;
    assign last_slot = (slot == 4'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            q         <= 2'd0;
            cnt       <= '0;
            slot      <= 4'd0;
            shreg     <= 8'd0;
            rd_op     <= 1'b0;
            nack      <= 1'b0;
            ack_smp   <= 1'b0;
            busy      <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            rsp_rdata <= 8'd0;
            rsp_ack   <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            q         <= q_nxt;
            cnt       <= cnt_nxt;
            slot      <= slot_nxt;
            shreg     <= shreg_nxt;
            rd_op     <= rd_op_nxt;
            nack      <= nack_nxt;
            ack_smp   <= ack_smp_nxt;
            busy      <= busy_nxt;
            scl_oe    <= scl_oe_nxt;
            sda_oe    <= sda_oe_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_ack   <= rsp_ack_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        q_nxt         = q;
        cnt_nxt       = cnt;
        slot_nxt      = slot;
        shreg_nxt     = shreg;
        rd_op_nxt     = rd_op;
        nack_nxt      = nack;
        ack_smp_nxt   = ack_smp;
        busy_nxt      = busy;
        scl_oe_nxt    = scl_oe;
        sda_oe_nxt    = sda_oe;
        rsp_rdata_nxt = rsp_rdata;
        rsp_ack_nxt   = rsp_ack;
        rsp_err_nxt   = rsp_err;

        if (active && !stretch) cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (active && q_end)    q_nxt   = q + 2'd1;

        // Line values below are those of the quarter being entered.
        case (state)
            S_IDLE, S_RESP: begin
                if (state == S_RESP) state_nxt = S_IDLE;
                if (cmd_valid) begin
                    cnt_nxt  = '0;
                    q_nxt    = 2'd0;
                    slot_nxt = 4'd0;
                    if (cmd_op == OP_START) begin
                        state_nxt  = S_START;
                        sda_oe_nxt = 1'b0;
                    end else if (!busy) begin
                        state_nxt   = S_RESP;
                        rsp_err_nxt = 1'b1;
                        rsp_ack_nxt = 1'b0;
                    end else if (cmd_op == OP_STOP) begin
                        state_nxt  = S_STOP;
                        sda_oe_nxt = 1'b1;
                    end else begin
                        state_nxt  = S_BIT;
                        rd_op_nxt  = (cmd_op == OP_READ);
                        nack_nxt   = cmd_rd_nack;
                        shreg_nxt  = cmd_wdata;
                        sda_oe_nxt = (cmd_op == OP_READ) ? 1'b0 : ~cmd_wdata[7];
                    end
                end
            end
            S_START: begin
                if (q_end) begin
                    case (q)
                        2'd0: scl_oe_nxt = 1'b0;
                        2'd1: sda_oe_nxt = 1'b1;
                        2'd2: scl_oe_nxt = 1'b1;
                        default: begin
                            state_nxt   = S_RESP;
                            busy_nxt    = 1'b1;
                            rsp_err_nxt = 1'b0;
                            rsp_ack_nxt = 1'b0;
                        end
                    endcase
                end
            end
            S_STOP: begin
                if (q_end) begin
                    case (q)
                        2'd0: scl_oe_nxt = 1'b0;
                        2'd1: sda_oe_nxt = 1'b0;
                        2'd2: ;
                        default: begin
                            state_nxt   = S_RESP;
                            busy_nxt    = 1'b0;
                            rsp_err_nxt = 1'b0;
                            rsp_ack_nxt = 1'b0;
                        end
                    endcase
                end
            end
            S_BIT: begin
                if (q_end) begin
                    case (q)
                        2'd0: scl_oe_nxt = 1'b0;
                        2'd1: ;
                        2'd2: begin
                            scl_oe_nxt = 1'b1;
                            if (last_slot) begin
                                ack_smp_nxt = ~rd_op & ~sda_i;
                            end else begin
                                shreg_nxt = {shreg[6:0], sda_i};
                                // Released a 1 but the line reads 0: another initiator won.
                                if (!rd_op && !sda_oe && !sda_i) begin
                                    state_nxt   = S_RESP;
                                    scl_oe_nxt  = 1'b0;
                                    sda_oe_nxt  = 1'b0;
                                    busy_nxt    = 1'b0;
                                    rsp_err_nxt = 1'b1;
                                    rsp_ack_nxt = 1'b0;
                                end
                            end
                        end
                        default: begin
                            if (last_slot) begin
                                state_nxt   = S_RESP;
                                rsp_err_nxt = 1'b0;
                                rsp_ack_nxt = ack_smp;
                                if (rd_op) rsp_rdata_nxt = shreg;
                            end else begin
                                slot_nxt = slot + 4'd1;
                                if (slot == 4'd7) sda_oe_nxt = rd_op & ~nack;
                                else              sda_oe_nxt = ~rd_op & ~shreg[7];
                            end
                        end
                    endcase
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_bert_controller.sv
// Bench for i2c_bert_controller: open-drain bus model, simple target, scoreboard of expected responses.
module tb_i2c_bert_controller;
    typedef struct {
        string      name;
        logic [1:0] op;
        logic [7:0] wd;
        logic       nk;
        int         tmode;
        logic [7:0] tbyte;
        int         lat;
        logic [7:0] rd;
        bit         chk_rd;
        logic       ack;
        logic       err;
        logic       bsy;
        logic [1:0] lines;
        int         n_start;
        int         n_stop;
        bit         chk_cap;
        logic [8:0] cap;
    } vec_t;

    typedef struct {
        string      name;
        int         acc;
        int         lat;
        logic [7:0] rd;
        bit         chk_rd;
        logic       ack;
        logic       err;
        logic       bsy;
        logic [1:0] lines;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       cmd_rd_nack = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_ack, rsp_err, busy;
    logic       scl_i, sda_i, scl_oe, sda_oe;
    logic       tb_scl_low = 1'b0;
    logic       tgt_sda_low;

    int         tgt_mode = 0;
    logic [7:0] tgt_byte = 8'd0;
    int         slot_base = 0;
    int         tgt_slot;

    int         cyc = 0;
    int         scl_falls = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic [8:0] cap = 9'd0;

    int         n_chk = 0;
    int         n_pass = 0;
    exp_t       sb[$];
    vec_t       tbl[9];

    i2c_bert_controller #(.CLKDIV(4), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_wdata(cmd_wdata), .cmd_rd_nack(cmd_rd_nack),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_ack(rsp_ack),
        .rsp_err(rsp_err), .busy(busy),
        .scl_i(scl_i), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    assign scl_i = ~scl_oe & ~tb_scl_low;
    assign sda_i = ~sda_oe & ~tgt_sda_low;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus observer: SCL falls, data captured on SCL rise, START/STOP conditions.
    always @(negedge clk) begin
        prev_scl <= scl_i;
        prev_sda <= sda_i;
        if (prev_scl && !scl_i) scl_falls <= scl_falls + 1;
        if (!prev_scl && scl_i) cap <= {cap[7:0], sda_i};
        if (prev_scl && scl_i && prev_sda && !sda_i) start_cnt <= start_cnt + 1;
        if (prev_scl && scl_i && !prev_sda && sda_i) stop_cnt <= stop_cnt + 1;
    end

    // Target: 1 = ACK a write, 2 = return tgt_byte, 3 = hold SDA low.
    always_comb begin
        tgt_slot    = scl_falls - slot_base;
        tgt_sda_low = 1'b0;
        case (tgt_mode)
            1: tgt_sda_low = (tgt_slot == 8);
            2: if (tgt_slot >= 0 && tgt_slot < 8) tgt_sda_low = ~tgt_byte[3'(7 - tgt_slot)];
            3: tgt_sda_low = 1'b1;
            default: tgt_sda_low = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] wd, input logic nk, input exp_t e);
        int n = 0;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_wdata   = wd;
        cmd_rd_nack = nk;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_chk++;
            $display("FAIL %s_accept: cmd_ready stayed low for %0d cycles", e.name, n);
        end else begin
            e.acc     = cyc;
            slot_base = scl_falls;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            n_chk++;
            $display("FAIL rsp_timeout: no rsp_valid after %0d cycles, expected one", n);
            sb.delete();
        end else if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL rsp_unexpected: rsp_valid with empty scoreboard, expected none");
        end else begin
            e = sb.pop_front();
            chk({e.name, "_lat"},   32'(cyc - e.acc), 32'(e.lat));
            chk({e.name, "_ack"},   32'(rsp_ack),     32'(e.ack));
            chk({e.name, "_err"},   32'(rsp_err),     32'(e.err));
            chk({e.name, "_busy"},  32'(busy),        32'(e.bsy));
            chk({e.name, "_lines"}, 32'({scl_oe, sda_oe}), 32'(e.lines));
            if (e.chk_rd) chk({e.name, "_rdata"}, 32'(rsp_rdata), 32'(e.rd));
        end
    endtask

    initial begin
        int s0, p0, f0, n;
        exp_t e;

        tbl[0] = '{"start",      2'd0, 8'h00, 1'b0, 0, 8'h00,  17, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1, 0, 1'b0, 9'h000};
        tbl[1] = '{"wr_a5_ack",  2'd1, 8'hA5, 1'b0, 1, 8'h00, 145, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 0, 0, 1'b1, 9'h14A};
        tbl[2] = '{"wr_5a_nack", 2'd1, 8'h5A, 1'b0, 0, 8'h00, 145, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 0, 0, 1'b1, 9'h0B5};
        tbl[3] = '{"rd_3c_nack", 2'd2, 8'h00, 1'b1, 2, 8'h3C, 145, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 0, 0, 1'b1, 9'h079};
        tbl[4] = '{"rd_c3_ack",  2'd2, 8'h00, 1'b0, 2, 8'hC3, 145, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 0, 0, 1'b1, 9'h186};
        tbl[5] = '{"rstart",     2'd0, 8'h00, 1'b0, 0, 8'h00,  17, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1, 0, 1'b0, 9'h000};
        tbl[6] = '{"stop",       2'd3, 8'h00, 1'b0, 0, 8'h00,  17, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 1, 1'b0, 9'h000};
        tbl[7] = '{"stop_idle",  2'd3, 8'h00, 1'b0, 0, 8'h00,   1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 1'b0, 9'h000};
        tbl[8] = '{"rd_idle",    2'd2, 8'h00, 1'b0, 0, 8'h00,   1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 1'b0, 9'h000};

        repeat (3) @(negedge clk);
        chk("rst_scl_oe",    32'(scl_oe),    32'd0);
        chk("rst_sda_oe",    32'(sda_oe),    32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_ack",   32'(rsp_ack),   32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            s0       = start_cnt;
            p0       = stop_cnt;
            tgt_mode = tbl[i].tmode;
            tgt_byte = tbl[i].tbyte;
            e = '{tbl[i].name, 0, tbl[i].lat, tbl[i].rd, tbl[i].chk_rd, tbl[i].ack,
                  tbl[i].err, tbl[i].bsy, tbl[i].lines};
            issue(tbl[i].op, tbl[i].wd, tbl[i].nk, e);
            wait_rsp();
            chk({tbl[i].name, "_starts"}, 32'(start_cnt - s0), 32'(tbl[i].n_start));
            chk({tbl[i].name, "_stops"},  32'(stop_cnt - p0),  32'(tbl[i].n_stop));
            if (tbl[i].chk_cap) chk({tbl[i].name, "_bus_bits"}, 32'(cap), 32'(tbl[i].cap));
            tgt_mode = 0;
        end

        // Clock stretch: 50 held cycles in slot 3 must add exactly 50 cycles.
        issue(2'd0, 8'h00, 1'b0, '{"st_start", 0, 17, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11});
        wait_rsp();
        tgt_mode = 1;
        issue(2'd1, 8'hA5, 1'b0, '{"st_wr", 0, 195, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10});
        begin
            logic prev = scl_oe;
            int   rel  = 0;
            n = 0;
            while (rel < 4 && n < 500) begin
                @(posedge clk);
                #1;
                if (prev && !scl_oe) rel++;
                prev = scl_oe;
                n++;
            end
            chk("st_slot3_found", 32'(rel), 32'd4);
            tb_scl_low = 1'b1;
            repeat (50) @(posedge clk);
            #1 tb_scl_low = 1'b0;
        end
        wait_rsp();
        tgt_mode = 0;
        issue(2'd3, 8'h00, 1'b0, '{"st_stop", 0, 17, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
        wait_rsp();

        // Arbitration loss on the first '1' bit, then a WRITE with the bus idle.
        issue(2'd0, 8'h00, 1'b0, '{"arb_start", 0, 17, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11});
        wait_rsp();
        tgt_mode = 3;
        issue(2'd1, 8'h80, 1'b0, '{"arb_wr", 0, 13, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
        wait_rsp();
        tgt_mode = 0;
        repeat (3) @(negedge clk);
        f0 = scl_falls;
        s0 = start_cnt;
        p0 = stop_cnt;
        issue(2'd1, 8'h11, 1'b0, '{"wr_idle", 0, 1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});
        wait_rsp();
        repeat (4) @(negedge clk);
        chk("wr_idle_scl_quiet", 32'(scl_falls - f0), 32'd0);
        chk("wr_idle_sda_quiet", 32'((start_cnt - s0) + (stop_cnt - p0)), 32'd0);

        // Asynchronous reset in the middle of a READ.
        issue(2'd0, 8'h00, 1'b0, '{"rs_start", 0, 17, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11});
        wait_rsp();
        tgt_mode = 2;
        tgt_byte = 8'h3C;
        issue(2'd2, 8'h00, 1'b1, '{"rs_rd", 0, 145, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10});
        repeat (20) @(posedge clk);
        n = 0;
        while (!scl_oe && n < 100) begin
            @(posedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_scl_oe",    32'(scl_oe),    32'd0);
        chk("arst_sda_oe",    32'(sda_oe),    32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst_busy",      32'(busy),      32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        sb.delete();
        tgt_mode = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt;
        issue(2'd0, 8'h00, 1'b0, '{"post_rst_start", 0, 17, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11});
        wait_rsp();
        chk("post_rst_starts", 32'(start_cnt - s0), 32'd1);
        issue(2'd3, 8'h00, 1'b0, '{"post_rst_stop", 0, 17, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
        wait_rsp();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
